// File: rtl/im_loader_if.sv
// im_loader_if: bundles the loader's control, byte-stream and memory-write
// signals.
//   master : host side. Drives start/word_count/in_valid/in_data and observes
//            in_ready, the write port and the status flags.
//   slave  : loader side, the mirror of master.
interface im_loader_if #(
  parameter int AW = 7
);
  logic          start;
  logic [AW:0]   word_count;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          busy;
  logic          cpu_hold;
  logic          done;
  logic          err;

  modport master (
    output start, word_count, in_valid, in_data,
    input  in_ready, we, waddr, wdata, busy, cpu_hold, done, err
  );

  modport slave (
    input  start, word_count, in_valid, in_data,
    output in_ready, we, waddr, wdata, busy, cpu_hold, done, err
  );
endinterface

// File: rtl/im_loader.sv
// im_loader: boot-time writer for the instruction memory.
// It takes a byte stream on a valid/ready handshake and packs every 4 bytes
// into one little-endian word. Each word goes out as a single-cycle write, to
// consecutive entries starting at entry 0. cpu_hold stays high while a load
// is in progress.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : im_loader_if.slave (start/word_count, byte stream, write port,
//            busy/cpu_hold/done/err)
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_RECV  | accepting bytes of the current word
// S_WRITE | one-cycle memory write of the assembled word
// S_DONE  | session finished; waits for the next start
module im_loader #(
  parameter int NMEM = 128,
  parameter int AW   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  im_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] LP_NMEM = (AW+1)'(NMEM);

  state_t        r_state,   w_state_nxt;
  logic [AW:0]   r_count,   w_count_nxt;
  logic [AW:0]   r_words,   w_words_nxt;
  logic [1:0]    r_byte,    w_byte_nxt;
  logic [AW-1:0] r_addr,    w_addr_nxt;
  logic [31:0]   r_wdata,   w_wdata_nxt;
  logic          r_err,     w_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_words <= '0;
      r_byte  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_words <= w_words_nxt;
      r_byte  <= w_byte_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_words_nxt = r_words;
    w_byte_nxt  = r_byte;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          if (bus.word_count > LP_NMEM) begin
            w_err_nxt = 1'b1;
          end else if (bus.word_count == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_count_nxt = bus.word_count;
            w_words_nxt = '0;
            w_byte_nxt  = '0;
            w_addr_nxt  = '0;
            w_state_nxt = S_RECV;
          end
        end
      end
      S_RECV: begin
        // in_ready is high in this state, so in_valid alone marks an accept.
        if (bus.in_valid) begin
          w_wdata_nxt[{r_byte, 3'b000} +: 8] = bus.in_data;
          w_byte_nxt = r_byte + 2'd1;
          if (r_byte == 2'd3) w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        // After the final word the address wraps to 0. It is never driven
        // onto the memory in that state, because we is low outside S_WRITE.
        w_addr_nxt  = r_addr + AW'(1);
        w_words_nxt = r_words + (AW+1)'(1);
        w_byte_nxt  = '0;
        if ((r_words + (AW+1)'(1)) == r_count) w_state_nxt = S_DONE;
        else                                   w_state_nxt = S_RECV;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Every output is either a register or a state decode. This means there is
  // no combinational path from in_valid to in_ready.
  assign bus.in_ready = (r_state == S_RECV);
  assign bus.we       = (r_state == S_WRITE);
  assign bus.busy     = (r_state == S_RECV) || (r_state == S_WRITE);
  assign bus.cpu_hold = bus.busy;
  assign bus.done     = (r_state == S_DONE);
  assign bus.err      = r_err;
  assign bus.waddr    = r_addr;
  assign bus.wdata    = r_wdata;

endmodule

// File: doc/im_loader.md
# im_loader

Boot-time writer for the core's 128-entry, 32-bit instruction memory, which the core reads combinationally by PC. It accepts a byte stream on a valid/ready handshake, assembles little-endian 32-bit words, and drives a single-cycle write port into consecutive memory entries starting at entry 0. While loading it holds the core off via `cpu_hold`, and it flags completion with `done`.

## Interface
Parameters:
- `NMEM`, 128, number of instruction memory entries.
- `AW`, 7, entry address width (log2 NMEM).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load session; sampled only in IDLE or DONE.
- `word_count`  in  AW+1  number of words to load; latched on accepted `start`.
- `in_valid`  in  1  byte available.
- `in_data`  in  8  byte value.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `we`  out  1  instruction memory write enable, one-cycle pulse per word.
- `waddr`  out  AW  entry address for the write.
- `wdata`  out  32  assembled word.
- `busy`  out  1  session in progress (RECV or WRITE).
- `cpu_hold`  out  1  equal to `busy`; keeps the core in reset or stalled.
- `done`  out  1  high in DONE state.
- `err`  out  1  one-cycle pulse when `start` is rejected because `word_count > NMEM`.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE or DONE with `start`=1:
  - `word_count` > NMEM: raise `err` for one cycle and stay in the current state. No writes occur.
  - `word_count` = 0: go to DONE.
  - Otherwise: latch the count, clear the word counter, byte index and address, then go to RECV.
- RECV:
  - `in_ready`=1.
  - A byte is accepted when `in_valid && in_ready`.
  - Byte k (k=0..3) of a word lands in `wdata[8k+7:8k]`, i.e. the first byte is the least significant.
  - On acceptance of byte 3, go to WRITE.
- WRITE (exactly one cycle):
  - `we`=1 with `waddr` equal to the current address and the assembled `wdata`; `in_ready`=0.
  - Then increment the address and word counter.
  - If the words written equal the latched count, go to DONE; otherwise go to RECV with the byte index reset to 0.
- DONE: `done`=1 and `in_ready`=0. The state persists until the next accepted `start`.
- `start` in RECV or WRITE is ignored (no restart, no `err`).
- `in_valid` outside RECV is ignored; bytes are not buffered.
- The address never wraps: the count is at most NMEM, so the last write is at `waddr`=NMEM-1.
- Reset, including mid-word or mid-session:
  - State returns to IDLE and any partial word is discarded.
  - Memory entries already written are not touched by the loader.
- Reset values:
  - State IDLE.
  - `in_ready`, `we`, `busy`, `cpu_hold`, `done`, `err` = 0.
  - `waddr`=0 and `wdata`=0.

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from `in_valid` to `in_ready`.
- `busy` and `in_ready` rise in the cycle after the edge that accepts `start`.
- `we` is asserted in the cycle after the edge that accepts byte 3.
- `waddr` and `wdata` are stable for the whole `we` cycle; the memory captures them on the following edge.
- Minimum throughput is 5 cycles per word (4 accepts plus 1 write). Each cycle that `in_valid` is low in RECV adds one cycle.
- `done` rises in the cycle after the final WRITE cycle; `busy` falls in that same cycle.
- `err` is asserted in the cycle after the rejected `start` edge and lasts exactly one cycle.
- A zero-length load reaches `done`=1 one cycle after `start`.

## Test plan
- Normal load:
  - Stimulus: `start` with `word_count`=2, then bytes 13 00 00 00 EF BE AD DE sent back-to-back.
  - Required response: `we` at `waddr`=0 with 0x00000013, then at `waddr`=1 with 0xDEADBEEF, with writes 5 cycles apart. `done`=1 and `busy`=0 exactly one cycle after the second write.
- Backpressure gaps:
  - Stimulus: same two words with random `in_valid` low cycles.
  - Required response: identical writes. No byte is lost or duplicated, and `in_ready`=0 during each WRITE cycle.
- Boundary counts:
  - `word_count`=0: `done` after 1 cycle, no `we`.
  - `word_count`=128 with ramp data (word n = n): 128 writes, last at `waddr`=127 with wdata 0x0000007F.
  - `word_count`=200: one-cycle `err`, state unchanged, no `we`, `busy` stays 0.
- Reset mid-word:
  - Stimulus: assert `rst_n`=0 after 2 bytes of the second word.
  - Required response: all outputs go to reset values immediately (asynchronously), no further `we`. A fresh session with `word_count`=1 then writes its word at `waddr`=0.
- Start while busy:
  - Stimulus: pulse `start` during RECV and during WRITE.
  - Required response: no restart, no `err`, and the original session completes unchanged. A `start` in DONE begins a new session with `done` falling.
